// File: rtl/fifo_arb_pkg.sv
// Package for the FIFO write-port arbiter.
// Holds the FSM state encoding and the default parameter values shared by
// the arbiter top and its round-robin picker.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 16;

  // IDLE : nobody owns the port, arbitrate among current requesters
  // WAIT : owner selected, waiting for a byte and for the FIFO to be free
  // WRITE: strobe cycle; decide whether the burst continues
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index of the last owner; search starts at (ptr+1) mod N
//   found out 1   at least one request present
//   index out IW  first requester found, wrapping N-1 -> 0
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW-1:0] cand;

  // Walk the candidates in priority order; the wrap is explicit so that a
  // non-power-of-two N never visits an index outside 0..N-1.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = ptr;
    for (int i = 0; i < N; i++) begin
      cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares one byte-wide FIFO write port among NUM_REQ
// producers with round-robin grants and bursts of up to MAX_BURST bytes.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            low freezes FSM, pointer, beat counter and grant
//   req/last/data     per-producer byte offer (byte i = data[i*DATA_W +: DATA_W])
//   ack               1-cycle pulse, producer i's byte was written
//   fifo_busy         FIFO cannot take a write this cycle
//   fifo_we/fifo_data write strobe and byte
//   grant_valid/id    current owner of the port
//
// Handshake: a producer raises req[i] with data/last and holds them stable
// until it sees ack[i]; it may change them the cycle after. fifo_busy acts as
// an inverted ready and is sampled in the same cycle the strobe is decided,
// so fifo_we never follows a cycle in which fifo_busy was high.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          last,
  input  logic [NUM_REQ*DATA_W-1:0]   data,
  output logic [NUM_REQ-1:0]          ack,
  input  logic                        fifo_busy,
  output logic                        fifo_we,
  output logic [DATA_W-1:0]           fifo_data,
  output logic                        grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);

  arb_state_t         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic               gv_q, gv_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               last_q, last_d;

  logic               pick_found;
  logic [IDW-1:0]     pick_idx;
  logic               sel_req, sel_last;
  logic [DATA_W-1:0]  sel_data;

  rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  // Owner's offer, selected by the registered grant.
  always_comb begin
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == IDW'(i)) begin
        sel_req  = req[i];
        sel_last = last[i];
        sel_data = data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= IDW'(NUM_REQ - 1);
      beat_q   <= '0;
      gid_q    <= '0;
      gv_q     <= 1'b0;
      we_q     <= 1'b0;
      data_q   <= '0;
      ack_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      gid_q    <= gid_d;
      gv_q     <= gv_d;
      we_q     <= we_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      last_q   <= last_d;
    end
  end

  // Strobe and ack default low every cycle: they are single-cycle pulses and
  // a frozen (enable=0) cycle must drop them while everything else holds.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    gid_d    = gid_q;
    gv_d     = gv_q;
    we_d     = 1'b0;
    data_d   = data_q;
    ack_d    = '0;
    last_d   = last_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            gid_d   = pick_idx;
            gv_d    = 1'b1;
            beat_d  = '0;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!sel_req) begin
            // Owner withdrew: release, and rotate past it.
            rr_ptr_d = gid_q;
            gv_d     = 1'b0;
            state_d  = ST_IDLE;
          end else if (!fifo_busy) begin
            we_d   = 1'b1;
            data_d = sel_data;
            for (int i = 0; i < NUM_REQ; i++) begin
              ack_d[i] = (gid_q == IDW'(i));
            end
            last_d  = sel_last;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          beat_d = beat_q + 1'b1;
          if (last_q || (beat_q == BW'(MAX_BURST - 1))) begin
            rr_ptr_d = gid_q;
            gv_d     = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: begin
          gv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign fifo_we     = we_q;
  assign fifo_data   = data_q;
  assign grant_valid = gv_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: producer queues drive req/data/last, a
// transaction-level round-robin model fills the expected write queue, and
// every strobe is checked against it along with timing rules.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 16;
  localparam int IDW       = $clog2(NUM_REQ);
  localparam int EW        = IDW + DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic                       clk = 1'b0;
  logic                       reset;
  logic                       enable;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         last;
  logic [NUM_REQ*DATA_W-1:0]  data;
  logic [NUM_REQ-1:0]         ack;
  logic                       fifo_busy;
  logic                       fifo_we;
  logic [DATA_W-1:0]          fifo_data;
  logic                       grant_valid;
  logic [IDW-1:0]             grant_id;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .last        (last),
    .data        (data),
    .ack         (ack),
    .fifo_busy   (fifo_busy),
    .fifo_we     (fifo_we),
    .fifo_data   (fifo_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W:0] prod_q [NUM_REQ][$];  // {last, byte}
  logic [EW-1:0]   exp_q[$];             // {producer, byte}
  int              wr_ids[$];
  int              model_ptr;
  int              writes_seen;
  int              grants_seen;
  logic            prev_we;
  logic            prev_gv;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; fifo_busy = 1'b0;
    req = '0; last = '0; data = '0;
    repeat (2) cycle();
    reset = 1'b0;
    model_ptr = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) prod_q[i].delete();
    exp_q.delete();
    wr_ids.delete();
    writes_seen = 0; grants_seen = 0;
    prev_we = 1'b0; prev_gv = 1'b0;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += prod_q[i].size();
    return s;
  endfunction

  // ---------------- driver ----------------
  task automatic push_byte(input int p, input logic [DATA_W-1:0] d, input logic l);
    prod_q[p].push_back({l, d});
  endtask

  task automatic drive_producers();
    logic [DATA_W:0] h;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (prod_q[i].size() > 0) begin
        h = prod_q[i][0];
        req[i] = 1'b1;
        data[i*DATA_W +: DATA_W] = h[DATA_W-1:0];
        last[i] = h[DATA_W];
      end else begin
        req[i] = 1'b0;
        last[i] = 1'b0;
      end
    end
  endtask

  // ---------------- reference model ----------------
  // Round-robin over non-empty producers starting after the last owner;
  // each grant drains bytes until a last flag or MAX_BURST bytes.
  task automatic build_expected();
    logic [DATA_W:0] tmp [NUM_REQ][$];
    logic [DATA_W:0] h;
    int g, beats, left;
    bit done;
    left = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tmp[i] = prod_q[i];
      left += tmp[i].size();
    end
    while (left > 0) begin
      g = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (model_ptr + k) % NUM_REQ;
        if (g < 0 && tmp[c].size() > 0) g = c;
      end
      beats = 0;
      done = 1'b0;
      while (!done) begin
        h = tmp[g].pop_front();
        left--;
        exp_q.push_back({IDW'(g), h[DATA_W-1:0]});
        beats++;
        done = h[DATA_W] || (beats == MAX_BURST) || (tmp[g].size() == 0);
      end
      model_ptr = g;
    end
  endtask

  // ---------------- one cycle with scoreboard ----------------
  task automatic step(input logic en, input logic busy);
    logic [EW-1:0]      e;
    logic [NUM_REQ-1:0] exp_ack;
    enable = en;
    fifo_busy = busy;
    drive_producers();
    cycle();
    if (grant_valid && !prev_gv) grants_seen++;
    prev_gv = grant_valid;
    if (fifo_we) begin
      writes_seen++;
      wr_ids.push_back(int'(grant_id));
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: fifo_data=%h ack=%b, required no write", fifo_data, ack);
      end else begin
        e = exp_q.pop_front();
        exp_ack = '0;
        exp_ack[e[EW-1:DATA_W]] = 1'b1;
        n_checks++;
        if (fifo_data !== e[DATA_W-1:0] || ack !== exp_ack) begin
          n_fail++;
          $display("FAIL write_content: data=%h ack=%b, required data=%h ack=%b",
                   fifo_data, ack, e[DATA_W-1:0], exp_ack);
        end
      end
      if (busy || !en || prev_we) begin
        n_fail++;
        $display("FAIL write_timing: fifo_we=1 after busy=%b enable=%b prev_we=%b, required busy=0 enable=1 prev_we=0",
                 busy, en, prev_we);
      end
    end else begin
      n_checks++;
      if (ack !== '0) begin
        n_fail++;
        $display("FAIL ack_without_we: ack=%b, required 0000", ack);
      end
    end
    prev_we = fifo_we;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
    end
  endtask

  task automatic run_traffic(input int busy_pct, input int en_pct);
    int c;
    build_expected();
    c = 0;
    while ((exp_q.size() > 0 || pending() > 0) && c < 3000) begin
      step($urandom_range(99) < en_pct, $urandom_range(99) < busy_pct);
      c++;
    end
    n_checks++;
    if (exp_q.size() != 0 || pending() != 0) begin
      n_fail++;
      $display("FAIL traffic_drain: %0d writes still expected, required 0", exp_q.size());
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (fifo_we !== 1'b0 || ack !== '0 || fifo_data !== '0 || grant_valid !== 1'b0 || grant_id !== '0) begin
      n_fail++;
      $display("FAIL reset_values: we=%b ack=%b data=%h gv=%b gid=%0d, required all zero",
               fifo_we, ack, fifo_data, grant_valid, grant_id);
    end
    // Reset while a write is pending in WAIT.
    push_byte(1, 8'h71, 1'b0);
    push_byte(1, 8'h72, 1'b0);
    push_byte(1, 8'h73, 1'b1);
    build_expected();
    repeat (3) step(1'b1, 1'b0);
    reset = 1'b1;
    drive_producers();
    cycle();
    n_checks++;
    if (fifo_we !== 1'b0 || ack !== '0 || grant_valid !== 1'b0 || grant_id !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: we=%b ack=%b gv=%b gid=%0d, required 0 0000 0 0",
               fifo_we, ack, grant_valid, grant_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    push_byte(0, 8'hA5, 1'b1);
    build_expected();
    step(1'b1, 1'b0);
    n_checks++;
    if (grant_valid !== 1'b1 || grant_id !== 0 || fifo_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: gv=%b gid=%0d we=%b, required 1 0 0", grant_valid, grant_id, fifo_we);
    end
    step(1'b1, 1'b0);
    n_checks++;
    if (fifo_we !== 1'b1 || fifo_data !== 8'hA5 || ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_write: we=%b data=%h ack=%b, required 1 a5 0001", fifo_we, fifo_data, ack);
    end
    step(1'b1, 1'b0);
    n_checks++;
    if (fifo_we !== 1'b0 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: we=%b gv=%b, required 0 0", fifo_we, grant_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int p = 0; p < NUM_REQ; p++) push_byte(p, DATA_W'(8'h10 + p), 1'b1);
    push_byte(0, 8'h20, 1'b1);
    run_traffic(0, 100);
    n_checks++;
    if (wr_ids.size() != 5 || grants_seen != 5) begin
      n_fail++;
      $display("FAIL rr_counts: writes=%0d grants=%0d, required 5 5", wr_ids.size(), grants_seen);
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (wr_ids[k] != exp_order[k]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: grant=%0d, required %0d", k, wr_ids[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_burst();
    do_reset();
    for (int i = 0; i < 20; i++) push_byte(0, DATA_W'(i), i == 19);
    push_byte(2, 8'hC0, 1'b0);
    push_byte(2, 8'hC1, 1'b1);
    run_traffic(0, 100);
    n_checks++;
    if (wr_ids.size() != 22) begin
      n_fail++;
      $display("FAIL burst_count: writes=%0d, required 22", wr_ids.size());
    end else begin
      n_checks++;
      if (wr_ids[15] != 0 || wr_ids[16] != 2 || wr_ids[17] != 2 || wr_ids[18] != 0) begin
        n_fail++;
        $display("FAIL burst_handover: ids[15..18]=%0d %0d %0d %0d, required 0 2 2 0",
                 wr_ids[15], wr_ids[16], wr_ids[17], wr_ids[18]);
      end
    end
  endtask

  task automatic test_busy();
    do_reset();
    push_byte(3, 8'h3C, 1'b1);
    build_expected();
    step(1'b1, 1'b1);
    n_checks++;
    if (grant_valid !== 1'b1 || grant_id !== 3) begin
      n_fail++;
      $display("FAIL busy_grant: gv=%b gid=%0d, required 1 3", grant_valid, grant_id);
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if (fifo_we !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_hold[%0d]: we=%b, required 0", k, fifo_we);
      end
    end
    step(1'b1, 1'b0);
    n_checks++;
    if (fifo_we !== 1'b1 || fifo_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL busy_release: we=%b data=%h, required 1 3c", fifo_we, fifo_data);
    end
    step(1'b1, 1'b0);
  endtask

  task automatic test_enable();
    int c;
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(0, DATA_W'(8'hE0 + i), i == 5);
    build_expected();
    c = 0;
    while (writes_seen < 2 && c < 20) begin
      step(1'b1, 1'b0);
      c++;
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (fifo_we !== 1'b0 || grant_valid !== 1'b1 || grant_id !== 0) begin
        n_fail++;
        $display("FAIL enable_freeze[%0d]: we=%b gv=%b gid=%0d, required 0 1 0",
                 k, fifo_we, grant_valid, grant_id);
      end
    end
    c = 0;
    while (exp_q.size() > 0 && c < 40) begin
      step(1'b1, 1'b0);
      c++;
    end
    n_checks++;
    if (writes_seen != 6 || grants_seen != 1) begin
      n_fail++;
      $display("FAIL enable_resume: writes=%0d grants=%0d, required 6 1", writes_seen, grants_seen);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0010;
    data[1*DATA_W +: DATA_W] = 8'h11;
    cycle();
    n_checks++;
    if (grant_valid !== 1'b1 || grant_id !== 1) begin
      n_fail++;
      $display("FAIL withdraw_grant: gv=%b gid=%0d, required 1 1", grant_valid, grant_id);
    end
    req = 4'b0000;
    cycle();
    n_checks++;
    if (fifo_we !== 1'b0 || ack !== '0 || grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_release: we=%b ack=%b gv=%b, required 0 0000 0", fifo_we, ack, grant_valid);
    end
    req = 4'b0101;
    cycle();
    n_checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2 || fifo_we !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_next: gv=%b gid=%0d we=%b, required 1 2 0", grant_valid, grant_id, fifo_we);
    end
    req = 4'b0000;
    cycle();
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int p = 0; p < NUM_REQ; p++) begin
        n = $urandom_range(20);
        for (int i = 0; i < n; i++) begin
          push_byte(p, DATA_W'($urandom_range(255)), (i == n - 1) || ($urandom_range(9) == 0));
        end
      end
      run_traffic(30, 85);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_busy();
    test_enable();
    test_withdraw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
